// File: rtl/pipe_control_unit_pkg.sv
// Shared constants for the pipelined MIPS-lite control unit: opcodes, ALU encodings
// and the layout of the control word carried down the pipe.
package pipe_control_unit_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_RTYPE = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    // Flag positions above the alu_op field; absolute bit = ALU_OP_W + F_*.
    localparam int FLAG_W      = 9;
    localparam int F_EXT_OP    = 0;
    localparam int F_REG_WRITE = 1;
    localparam int F_ALU_SRC   = 2;
    localparam int F_MEM_WRITE = 3;
    localparam int F_MEM_READ  = 4;
    localparam int F_WB_MUX    = 5;
    localparam int F_JMP       = 6;
    localparam int F_BRANCH    = 7;
    localparam int F_REG_DST   = 8;

    localparam int ALU_OP_W_DEF = 3;
    localparam int CTRL_W       = FLAG_W + ALU_OP_W_DEF;
    localparam int MEM_CTRL_W   = 4;
    localparam int WB_CTRL_W    = 2;

    typedef struct packed {
        logic reg_dst;
        logic branch;
        logic jmp;
        logic wb_mux;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic ext_op;
    } ctrl_flags_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational main decoder: opcode/valid to control word, illegal flag and
// whether the instruction reads rt (for load-use detection).
module control_decoder
    import pipe_control_unit_pkg::*;
#(
    parameter int ALU_OP_W = 3
) (
    input  logic [5:0]                 op,
    input  logic                       valid,
    output logic [FLAG_W+ALU_OP_W-1:0] ctrl,
    output logic                       illegal,
    output logic                       uses_rt
);

    ctrl_flags_t flags_s;
    logic [2:0]  alu_s;
    logic        unknown_s;

    // Opcode table; an unknown opcode leaves the word all-zero.
    always_comb begin
        flags_s   = '0;
        alu_s     = ALU_ADD;
        unknown_s = 1'b0;
        uses_rt   = 1'b0;
        case (op)
            OP_R: begin
                flags_s.reg_dst   = 1'b1;
                flags_s.reg_write = 1'b1;
                alu_s             = ALU_RTYPE;
                uses_rt           = 1'b1;
            end
            OP_ORI: begin
                flags_s.alu_src   = 1'b1;
                flags_s.reg_write = 1'b1;
                alu_s             = ALU_OR;
            end
            OP_XORI: begin
                flags_s.alu_src   = 1'b1;
                flags_s.reg_write = 1'b1;
                alu_s             = ALU_XOR;
            end
            OP_LUI: begin
                flags_s.alu_src   = 1'b1;
                flags_s.reg_write = 1'b1;
                alu_s             = ALU_LUI;
            end
            OP_ADDIU: begin
                flags_s.alu_src   = 1'b1;
                flags_s.reg_write = 1'b1;
                flags_s.ext_op    = 1'b1;
            end
            OP_LW: begin
                flags_s.wb_mux    = 1'b1;
                flags_s.mem_read  = 1'b1;
                flags_s.alu_src   = 1'b1;
                flags_s.reg_write = 1'b1;
                flags_s.ext_op    = 1'b1;
            end
            OP_SW: begin
                flags_s.mem_write = 1'b1;
                flags_s.alu_src   = 1'b1;
                flags_s.ext_op    = 1'b1;
                uses_rt           = 1'b1;
            end
            OP_BEQ: begin
                flags_s.branch    = 1'b1;
                flags_s.ext_op    = 1'b1;
                alu_s             = ALU_SUB;
                uses_rt           = 1'b1;
            end
            OP_JAL: begin
                flags_s.jmp       = 1'b1;
                flags_s.reg_write = 1'b1;
            end
            default: unknown_s = 1'b1;
        endcase
    end

    assign ctrl    = valid ? {flags_s, ALU_OP_W'(alu_s)} : {(FLAG_W+ALU_OP_W){1'b0}};
    assign illegal = valid & unknown_s;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and resolves freeze, redirect flush and load-use stall.
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 id_op,
    input  logic [REG_AW-1:0]          id_rs,
    input  logic [REG_AW-1:0]          id_rt,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_valid,
    input  logic                       ex_redirect,
    input  logic                       mem_busy,
    output logic                       pc_en,
    output logic                       if_id_en,
    output logic                       if_id_flush,
    output logic [FLAG_W+ALU_OP_W-1:0] ex_ctrl,
    output logic [REG_AW-1:0]          ex_dst,
    output logic [MEM_CTRL_W-1:0]      mem_ctrl,
    output logic [REG_AW-1:0]          mem_dst,
    output logic [WB_CTRL_W-1:0]       wb_ctrl,
    output logic [REG_AW-1:0]          wb_dst,
    output logic                       ex_illegal,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int CW          = FLAG_W + ALU_OP_W;
    localparam int B_REG_DST   = ALU_OP_W + F_REG_DST;
    localparam int B_JMP       = ALU_OP_W + F_JMP;
    localparam int B_WB_MUX    = ALU_OP_W + F_WB_MUX;
    localparam int B_MEM_READ  = ALU_OP_W + F_MEM_READ;
    localparam int B_MEM_WRITE = ALU_OP_W + F_MEM_WRITE;
    localparam int B_REG_WRITE = ALU_OP_W + F_REG_WRITE;

    logic [CW-1:0]         dec_ctrl;
    logic                  dec_illegal;
    logic                  dec_uses_rt;
    logic [REG_AW-1:0]     dec_dst;
    logic                  load_use;
    logic [CNT_W-1:0]      cnt_inc;

    logic [CW-1:0]         ex_ctrl_d,    ex_ctrl_q;
    logic [REG_AW-1:0]     ex_dst_d,     ex_dst_q;
    logic                  ex_illegal_d, ex_illegal_q;
    logic [MEM_CTRL_W-1:0] mem_ctrl_d,   mem_ctrl_q;
    logic [REG_AW-1:0]     mem_dst_d,    mem_dst_q;
    logic [WB_CTRL_W-1:0]  wb_ctrl_d,    wb_ctrl_q;
    logic [REG_AW-1:0]     wb_dst_d,     wb_dst_q;
    logic [CNT_W-1:0]      stall_cnt_d,  stall_cnt_q;

    control_decoder #(.ALU_OP_W(ALU_OP_W)) u_decoder (
        .op      (id_op),
        .valid   (id_valid),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .uses_rt (dec_uses_rt)
    );

    // Non-writing instructions carry dst=0 so they never match a hazard compare.
    always_comb begin
        if (!dec_ctrl[B_REG_WRITE]) begin
            dec_dst = {REG_AW{1'b0}};
        end else if (dec_ctrl[B_REG_DST]) begin
            dec_dst = id_rd;
        end else if (dec_ctrl[B_JMP]) begin
            dec_dst = REG_AW'(LINK_REG);
        end else begin
            dec_dst = id_rt;
        end
    end

    assign load_use = ex_ctrl_q[B_MEM_READ] && (ex_dst_q != {REG_AW{1'b0}}) &&
                      ((ex_dst_q == id_rs) || (dec_uses_rt && (ex_dst_q == id_rt)));

    assign cnt_inc = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                    : stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Hazard priority: reset, freeze, redirect, load-use, normal advance.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        ex_ctrl_d    = ex_ctrl_q;
        ex_dst_d     = ex_dst_q;
        ex_illegal_d = ex_illegal_q;
        mem_ctrl_d   = mem_ctrl_q;
        mem_dst_d    = mem_dst_q;
        wb_ctrl_d    = wb_ctrl_q;
        wb_dst_d     = wb_dst_q;
        stall_cnt_d  = stall_cnt_q;
        if (rst) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            stall_cnt_d = cnt_inc;
        end else begin
            wb_ctrl_d  = mem_ctrl_q[WB_CTRL_W-1:0];
            wb_dst_d   = mem_dst_q;
            mem_ctrl_d = {ex_ctrl_q[B_MEM_READ], ex_ctrl_q[B_MEM_WRITE],
                          ex_ctrl_q[B_WB_MUX],   ex_ctrl_q[B_REG_WRITE]};
            mem_dst_d  = ex_dst_q;
            if (ex_redirect) begin
                if_id_flush  = 1'b1;
                ex_ctrl_d    = {CW{1'b0}};
                ex_dst_d     = {REG_AW{1'b0}};
                ex_illegal_d = 1'b0;
                stall_cnt_d  = cnt_inc;
            end else if (load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                ex_ctrl_d    = {CW{1'b0}};
                ex_dst_d     = {REG_AW{1'b0}};
                ex_illegal_d = 1'b0;
                stall_cnt_d  = cnt_inc;
            end else begin
                ex_ctrl_d    = dec_ctrl;
                ex_dst_d     = dec_dst;
                ex_illegal_d = dec_illegal;
            end
        end
    end

    // Pipe control registers and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q    <= {CW{1'b0}};
            ex_dst_q     <= {REG_AW{1'b0}};
            ex_illegal_q <= 1'b0;
            mem_ctrl_q   <= {MEM_CTRL_W{1'b0}};
            mem_dst_q    <= {REG_AW{1'b0}};
            wb_ctrl_q    <= {WB_CTRL_W{1'b0}};
            wb_dst_q     <= {REG_AW{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_dst_q     <= ex_dst_d;
            ex_illegal_q <= ex_illegal_d;
            mem_ctrl_q   <= mem_ctrl_d;
            mem_dst_q    <= mem_dst_d;
            wb_ctrl_q    <= wb_ctrl_d;
            wb_dst_q     <= wb_dst_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign ex_dst     = ex_dst_q;
    assign ex_illegal = ex_illegal_q;
    assign mem_ctrl   = mem_ctrl_q;
    assign mem_dst    = mem_dst_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign wb_dst     = wb_dst_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios then random traffic, each cycle
// compared against a flag-level reference model of the pipe.
module tb_pipe_control_unit;

    localparam int AW   = 5;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst, id_valid, ex_redirect, mem_busy;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        pc_en, if_id_en, if_id_flush, ex_illegal;
    logic [11:0] ex_ctrl;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic [3:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_control_unit #(.CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_valid(id_valid), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .ex_ctrl(ex_ctrl), .ex_dst(ex_dst), .mem_ctrl(mem_ctrl), .mem_dst(mem_dst),
        .wb_ctrl(wb_ctrl), .wb_dst(wb_dst), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference pipe contents, described per stage.
    logic [11:0] e_ctrl;
    logic [4:0]  e_dst;
    logic        e_ill;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_dst;
    logic [1:0]  w_ctrl;
    logic [4:0]  w_dst;
    int          cnt;

    logic [5:0] ops [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_ctrl(input logic [5:0] op, input logic v);
        logic reg_dst = 1'b0, branch = 1'b0, jmp = 1'b0, wb_mux = 1'b0, mem_read = 1'b0;
        logic mem_write = 1'b0, alu_src = 1'b0, reg_write = 1'b0, ext_op = 1'b0;
        logic [2:0] alu = 3'b000;
        if (v) begin
            case (op)
                6'b000000: begin reg_dst = 1'b1; reg_write = 1'b1; alu = 3'b011; end
                6'b001101: begin alu_src = 1'b1; reg_write = 1'b1; alu = 3'b010; end
                6'b001110: begin alu_src = 1'b1; reg_write = 1'b1; alu = 3'b100; end
                6'b001111: begin alu_src = 1'b1; reg_write = 1'b1; alu = 3'b101; end
                6'b001001: begin alu_src = 1'b1; reg_write = 1'b1; ext_op = 1'b1; end
                6'b100011: begin wb_mux = 1'b1; mem_read = 1'b1; alu_src = 1'b1;
                                 reg_write = 1'b1; ext_op = 1'b1; end
                6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; ext_op = 1'b1; end
                6'b000100: begin branch = 1'b1; ext_op = 1'b1; alu = 3'b001; end
                6'b000011: begin jmp = 1'b1; reg_write = 1'b1; end
                default: ;
            endcase
        end
        return {reg_dst, branch, jmp, wb_mux, mem_read, mem_write, alu_src, reg_write, ext_op, alu};
    endfunction

    function automatic logic ref_illegal(input logic [5:0] op, input logic v);
        logic known;
        known = (op == 6'b000000) || (op == 6'b001101) || (op == 6'b001110) ||
                (op == 6'b001111) || (op == 6'b001001) || (op == 6'b100011) ||
                (op == 6'b101011) || (op == 6'b000100) || (op == 6'b000011);
        return v && !known;
    endfunction

    function automatic logic ref_uses_rt(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b000100) || (op == 6'b101011);
    endfunction

    function automatic logic [4:0] ref_dst(input logic [11:0] c);
        if (!c[4]) return 5'd0;
        if (c[11]) return id_rd;
        if (c[9])  return 5'd31;
        return id_rt;
    endfunction

    // Advance the reference model by one clock with the current inputs.
    task automatic model_edge(input logic hz);
        if (rst) begin
            e_ctrl = 12'd0; e_dst = 5'd0; e_ill = 1'b0;
            m_ctrl = 4'd0;  m_dst = 5'd0; w_ctrl = 2'd0; w_dst = 5'd0; cnt = 0;
        end else if (mem_busy) begin
            cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        end else begin
            w_ctrl = m_ctrl[1:0];
            w_dst  = m_dst;
            m_ctrl = {e_ctrl[7], e_ctrl[6], e_ctrl[8], e_ctrl[4]};
            m_dst  = e_dst;
            if (ex_redirect || hz) begin
                e_ctrl = 12'd0; e_dst = 5'd0; e_ill = 1'b0;
                cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
            end else begin
                e_ctrl = ref_ctrl(id_op, id_valid);
                e_dst  = ref_dst(e_ctrl);
                e_ill  = ref_illegal(id_op, id_valid);
            end
        end
    endtask

    task automatic cycle();
        logic hz, x_go, x_flush;
        @(negedge clk);
        hz = e_ctrl[7] && (e_dst != 5'd0) &&
             ((e_dst == id_rs) || (ref_uses_rt(id_op) && (e_dst == id_rt)));
        x_go    = rst || (!mem_busy && (ex_redirect || !hz));
        x_flush = !rst && !mem_busy && ex_redirect;
        chk("pc_en",       32'(pc_en),       32'(x_go));
        chk("if_id_en",    32'(if_id_en),    32'(x_go));
        chk("if_id_flush", 32'(if_id_flush), 32'(x_flush));
        chk("ex_ctrl",     32'(ex_ctrl),     32'(e_ctrl));
        chk("ex_dst",      32'(ex_dst),      32'(e_dst));
        chk("ex_illegal",  32'(ex_illegal),  32'(e_ill));
        chk("mem_ctrl",    32'(mem_ctrl),    32'(m_ctrl));
        chk("mem_dst",     32'(mem_dst),     32'(m_dst));
        chk("wb_ctrl",     32'(wb_ctrl),     32'(w_ctrl));
        chk("wb_dst",      32'(wb_dst),      32'(w_dst));
        chk("stall_cnt",   32'(stall_cnt),   32'(cnt));
        @(posedge clk);
        model_edge(hz);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic v);
        id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; id_valid = v;
    endtask

    initial begin
        ops[0] = 6'b000000; ops[1] = 6'b001101; ops[2] = 6'b001110; ops[3] = 6'b001111;
        ops[4] = 6'b001001; ops[5] = 6'b100011; ops[6] = 6'b101011; ops[7] = 6'b000100;
        ops[8] = 6'b000011; ops[9] = 6'b100011;

        rst = 1'b1; mem_busy = 1'b0; ex_redirect = 1'b0;
        set_id(6'b100011, 5'd0, 5'd0, 5'd0, 1'b1);
        @(posedge clk); #1;
        model_edge(1'b0);
        cycle(); cycle();
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);

        // LW flows through EX, MEM and WB.
        rst = 1'b0;
        set_id(6'b100011, 5'd1, 5'd2, 5'd0, 1'b1); cycle();
        chk("lw_ex", 32'(ex_ctrl), 32'h1B8);
        set_id(6'b000000, 5'd0, 5'd0, 5'd0, 1'b0); cycle();
        chk("lw_mem", 32'(mem_ctrl), 32'hB);
        cycle();
        chk("lw_wb", 32'(wb_ctrl), 32'h3);

        // Load-use stall, then the same pair with rt=0.
        set_id(6'b100011, 5'd0, 5'd5, 5'd0, 1'b1); cycle();
        set_id(6'b000000, 5'd5, 5'd3, 5'd4, 1'b1); cycle();
        chk("lu_bubble", 32'(ex_ctrl), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        cycle();
        chk("lu_r_ex", 32'(ex_ctrl), 32'h813);
        chk("lu_r_dst", 32'(ex_dst), 32'd4);
        set_id(6'b100011, 5'd0, 5'd0, 5'd0, 1'b1); cycle();
        set_id(6'b000000, 5'd0, 5'd3, 5'd4, 1'b1); cycle();
        chk("nolu_r_ex", 32'(ex_ctrl), 32'h813);
        chk("nolu_cnt", 32'(stall_cnt), 32'd1);

        // Redirect coinciding with a load-use match.
        set_id(6'b100011, 5'd0, 5'd6, 5'd0, 1'b1); cycle();
        set_id(6'b000000, 5'd6, 5'd1, 5'd2, 1'b1); ex_redirect = 1'b1; cycle();
        ex_redirect = 1'b0;
        chk("rd_bubble", 32'(ex_ctrl), 32'd0);
        chk("rd_cnt", 32'(stall_cnt), 32'd2);

        // Freeze for three cycles with LW sitting in MEM.
        set_id(6'b100011, 5'd0, 5'd7, 5'd0, 1'b1); cycle();
        set_id(6'b001101, 5'd1, 5'd2, 5'd0, 1'b1); cycle();
        mem_busy = 1'b1;
        cycle(); cycle(); cycle();
        mem_busy = 1'b0;
        chk("frz_mem", 32'(mem_ctrl), 32'hB);
        chk("frz_cnt", 32'(stall_cnt), 32'd5);

        // JAL links to r31; an unknown opcode is flagged with a zero word.
        set_id(6'b000011, 5'd0, 5'd2, 5'd7, 1'b1); cycle();
        chk("jal_dst", 32'(ex_dst), 32'd31);
        chk("jal_ctrl", 32'(ex_ctrl), 32'h210);
        set_id(6'b111111, 5'd0, 5'd0, 5'd0, 1'b1); cycle();
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_ctrl", 32'(ex_ctrl), 32'd0);

        // Counter saturation over a long freeze.
        rst = 1'b1; cycle(); rst = 1'b0;
        mem_busy = 1'b1;
        repeat (20) cycle();
        mem_busy = 1'b0;
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        rst = 1'b1; cycle(); rst = 1'b0;

        // Random traffic with small register numbers to provoke hazards.
        repeat (400) begin
            rst         = ($urandom_range(0, 49) == 0);
            mem_busy    = ($urandom_range(0, 9) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            id_valid    = ($urandom_range(0, 7) != 0);
            id_op       = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
